// File: rtl/permute_check_scheduler_if.sv
// Pair-stream, datapath and job-total signals of the permute_check_scheduler.
// outZeroCount exists only when PERMUTE_SCHED_ZERO_COUNT_EN is defined.
interface permute_check_scheduler_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   inValid;
  logic                   inReady;
  logic [127:0]           inTop;
  logic [127:0]           inBot;
  logic                   inLast;
  logic                   checkValid;
  logic [127:0]           checkTop;
  logic [127:0]           checkBot;
  logic [23:0]            checkResult;
  logic                   outValid;
  logic                   outReady;
  logic [COUNT_WIDTH-1:0] outPermCount;
  logic [COUNT_WIDTH-1:0] outPairCount;
`ifdef PERMUTE_SCHED_ZERO_COUNT_EN
  logic [COUNT_WIDTH-1:0] outZeroCount;
`endif
  logic                   busy;

  // slave: the scheduler itself; master: the surrounding provider/datapath/collector
  modport slave (
    input  inValid, inTop, inBot, inLast, checkResult, outReady,
`ifdef PERMUTE_SCHED_ZERO_COUNT_EN
    output outZeroCount,
`endif
    output inReady, checkValid, checkTop, checkBot, outValid,
    output outPermCount, outPairCount, busy
  );

  modport master (
    output inValid, inTop, inBot, inLast, checkResult, outReady,
`ifdef PERMUTE_SCHED_ZERO_COUNT_EN
    input  outZeroCount,
`endif
    input  inReady, checkValid, checkTop, checkBot, outValid,
    input  outPermCount, outPairCount, busy
  );
endinterface

// File: rtl/permute_check_scheduler.sv
// Issues (top, bot) pairs to the fixed-latency permuteCheck24 datapath and totals results per job.
// Optional zero-result counter: define PERMUTE_SCHED_ZERO_COUNT_EN.
module permute_check_scheduler #(
  parameter int CHECK_LATENCY = 2,
  parameter int COUNT_WIDTH   = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  permute_check_scheduler_if.slave bus
);

  if (CHECK_LATENCY < 0 || CHECK_LATENCY > 15) begin : g_bad_latency
    $error("CHECK_LATENCY must be within 0..15");
  end
  if (COUNT_WIDTH < 6) begin : g_bad_width
    $error("COUNT_WIDTH must be at least 6");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   live;
  logic                   accept;
  logic                   capture;
  logic [CHECK_LATENCY:0] inflight;
  logic [127:0]           top_q, bot_q;
  logic [4:0]             pop;
  logic [COUNT_WIDTH-1:0] perm_acc, pair_acc;
  logic [COUNT_WIDTH:0]   perm_sum;
  logic [COUNT_WIDTH-1:0] perm_nxt, pair_nxt;
  logic                   clear;

  assign accept  = bus.inValid && bus.inReady;
  // inflight[0] is the issue strobe; the top tap lines up with the datapath result
  assign capture = inflight[CHECK_LATENCY];
  assign clear   = (state == DONE) && bus.outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.inLast ? DRAIN : RUN;
      RUN:     if (accept && bus.inLast) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = DONE;
      DONE:    if (bus.outReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      top_q    <= '0;
      bot_q    <= '0;
    end else begin
      inflight[0] <= accept;
      for (int k = 1; k <= CHECK_LATENCY; k++) inflight[k] <= inflight[k-1];
      if (accept) begin
        top_q <= bus.inTop;
        bot_q <= bus.inBot;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < 24; i++) pop = pop + 5'(bus.checkResult[i]);
  end

  // Saturating adds: one spare bit catches the perm overflow, all-ones stops the pair count
  assign perm_sum = {1'b0, perm_acc} + (COUNT_WIDTH+1)'(pop);
  assign perm_nxt = perm_sum[COUNT_WIDTH] ? '1 : perm_sum[COUNT_WIDTH-1:0];
  assign pair_nxt = (&pair_acc) ? pair_acc : pair_acc + COUNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_acc <= '0;
      pair_acc <= '0;
    end else if (clear) begin
      perm_acc <= '0;
      pair_acc <= '0;
    end else if (capture) begin
      perm_acc <= perm_nxt;
      pair_acc <= pair_nxt;
    end
  end

`ifdef PERMUTE_SCHED_ZERO_COUNT_EN
  logic [COUNT_WIDTH-1:0] zero_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc <= '0;
    end else if (clear) begin
      zero_acc <= '0;
    end else if (capture && bus.checkResult == 24'h0 && !(&zero_acc)) begin
      zero_acc <= zero_acc + COUNT_WIDTH'(1);
    end
  end

  assign bus.outZeroCount = zero_acc;
`endif

  assign bus.inReady      = live && (state == IDLE || state == RUN);
  assign bus.checkValid   = inflight[0];
  assign bus.checkTop     = top_q;
  assign bus.checkBot     = bot_q;
  assign bus.outValid     = (state == DONE);
  assign bus.outPermCount = perm_acc;
  assign bus.outPairCount = pair_acc;
  assign bus.busy         = (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_permute_check_scheduler.sv
// Randomized self-checking bench: job totals predicted from per-pair datapath results.
module tb_permute_check_scheduler;
  localparam int L0 = 2, CW0 = 32;
  localparam int L1 = 3, CW1 = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  permute_check_scheduler_if #(.COUNT_WIDTH(CW0)) b0();
  permute_check_scheduler_if #(.COUNT_WIDTH(CW1)) b1();

  permute_check_scheduler #(.CHECK_LATENCY(L0), .COUNT_WIDTH(CW0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  permute_check_scheduler #(.CHECK_LATENCY(L1), .COUNT_WIDTH(CW1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: result for a pair appears exactly latency cycles after its issue strobe
  bit          rforce = 1'b0;
  logic [23:0] rconst = '0;
  function automatic logic [23:0] dp_fn(input logic [127:0] t, input logic [127:0] b);
    return rforce ? rconst : (t[23:0] ^ b[119:96]);
  endfunction

  logic [23:0] dp0 [1:15];
  logic [23:0] dp1 [1:15];
  always @(posedge clk) begin
    dp0[1] <= b0.checkValid ? dp_fn(b0.checkTop, b0.checkBot) : 24'($urandom);
    dp1[1] <= b1.checkValid ? dp_fn(b1.checkTop, b1.checkBot) : 24'($urandom);
    for (int k = 2; k <= 15; k++) begin
      dp0[k] <= dp0[k-1];
      dp1[k] <= dp1[k-1];
    end
  end
  assign b0.checkResult = dp0[L0];
  assign b1.checkResult = dp1[L1];

  int cv0_cnt = 0, cv0_run = 0, cv0_max = 0, cv1_cnt = 0;
  always @(negedge clk) begin
    if (b0.checkValid) begin
      cv0_cnt++; cv0_run++;
      if (cv0_run > cv0_max) cv0_max = cv0_run;
    end else cv0_run = 0;
    if (b1.checkValid) cv1_cnt++;
  end

  logic [CW0-1:0] exp_perm0, exp_pair0;

  task automatic release0(input string nm);
    b0.inValid = 1'b0; b0.outReady = 1'b1;
    @(negedge clk);
    b0.outReady = 1'b0;
    tests++;
    if (b0.outValid !== 1'b0 || b0.inReady !== 1'b1 || b0.outPairCount !== '0 || b0.outPermCount !== '0) begin
      fails++;
      $display("FAIL %s release: outValid=%b inReady=%b pairs=%0d perm=%0d, want 0 1 0 0",
               nm, b0.outValid, b0.inReady, b0.outPairCount, b0.outPermCount);
    end
  endtask

  // Runs one job on dut0 from IDLE, checks issue, totals and latency, leaves it in DONE unless rel
  task automatic drive_job0(input string nm, input int n, input int bubble_pct, input bit top_zero, input bit rel);
    logic [127:0] pt, pb;
    logic [23:0]  r;
    longint perm = 0;
    int zero = 0, sent = 0, last_t = 0, waited = 0;
    bit prev_acc = 0, rdy_ok = 1, iss_ok = 1;
    cv0_cnt = 0; cv0_max = 0;
    pt = '0; pb = '0;
    while (sent < n) begin
      @(negedge clk);
      if (prev_acc ? (b0.checkValid !== 1'b1 || b0.checkTop !== pt || b0.checkBot !== pb)
                   : (b0.checkValid !== 1'b0)) iss_ok = 0;
      if (b0.inReady !== 1'b1) rdy_ok = 0;
      if ($urandom_range(99) < bubble_pct) begin
        b0.inValid = 1'b0;
        b0.inTop = {$urandom, $urandom, $urandom, $urandom};
        b0.inLast = 1'($urandom);
        prev_acc = 0;
      end else begin
        pt = top_zero ? '0 : {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        b0.inValid = 1'b1; b0.inTop = pt; b0.inBot = pb; b0.inLast = (sent == n - 1);
        r = dp_fn(pt, pb);
        perm += $countones(r);
        if (r == 24'h0) zero++;
        sent++; last_t = cyc; prev_acc = 1;
      end
    end
    @(negedge clk);
    if (b0.checkValid !== 1'b1 || b0.checkTop !== pt || b0.checkBot !== pb) iss_ok = 0;
    while (b0.outValid !== 1'b1 && waited < 60) begin
      b0.inValid = 1'($urandom); b0.inLast = 1'($urandom);
      b0.inTop = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      waited++;
    end
    exp_perm0 = (perm > 64'hFFFF_FFFF) ? '1 : CW0'(perm);
    exp_pair0 = CW0'(n);
    tests++;
    if (waited >= 60) begin
      fails++; $display("FAIL %s timeout: outValid never rose within 60 cycles", nm);
    end
    tests++;
    if (iss_ok !== 1'b1 || rdy_ok !== 1'b1) begin
      fails++; $display("FAIL %s issue: issue_ok=%b ready_ok=%b, want 1 1", nm, iss_ok, rdy_ok);
    end
    tests++;
    if (cyc - last_t !== 3 + L0) begin
      fails++; $display("FAIL %s latency: got %0d want %0d", nm, cyc - last_t, 3 + L0);
    end
    tests++;
    if (b0.outPermCount !== exp_perm0 || b0.outPairCount !== exp_pair0) begin
      fails++; $display("FAIL %s totals: perm=%0d pairs=%0d want %0d %0d",
                        nm, b0.outPermCount, b0.outPairCount, exp_perm0, exp_pair0);
    end
    tests++;
    if (cv0_cnt !== n || b0.busy !== 1'b0 || b0.inReady !== 1'b0) begin
      fails++; $display("FAIL %s strobes: checkValid count=%0d busy=%b inReady=%b want %0d 0 0",
                        nm, cv0_cnt, b0.busy, b0.inReady, n);
    end
`ifdef PERMUTE_SCHED_ZERO_COUNT_EN
    tests++;
    if (b0.outZeroCount !== CW0'(zero)) begin
      fails++; $display("FAIL %s zero_count: got %0d want %0d", nm, b0.outZeroCount, zero);
    end
`endif
    if (rel) release0(nm);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({b0.inReady, b0.checkValid, b0.outValid, b0.busy, b1.inReady, b1.checkValid, b1.outValid, b1.busy} !== 8'h0 ||
        b0.checkTop !== '0 || b0.checkBot !== '0 || b0.outPermCount !== '0 || b0.outPairCount !== '0 ||
        b1.outPermCount !== '0 || b1.outPairCount !== '0) begin
      fails++; $display("FAIL reset_state: inReady=%b checkValid=%b outValid=%b busy=%b perm=%0d, want all 0",
                        b0.inReady, b0.checkValid, b0.outValid, b0.busy, b0.outPermCount);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (b0.inReady !== 1'b1 || b1.inReady !== 1'b1 || b0.busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: inReady=%b/%b busy=%b want 1/1 0", b0.inReady, b1.inReady, b0.busy);
    end
  endtask

  task automatic test_single();
    rforce = 1'b1; rconst = 24'hFFFFFF;
    drive_job0("single", 1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    rforce = 1'b1; rconst = 24'h800001;
    drive_job0("back_to_back", 16, 0, 1'b0, 1'b0);
    tests++;
    if (cv0_max !== 16) begin
      fails++; $display("FAIL back_to_back run: longest checkValid run=%0d want 16", cv0_max);
    end
    release0("back_to_back");
  endtask

  task automatic test_zero_results();
    rforce = 1'b1; rconst = 24'h0;
    drive_job0("zero_results", 3, 20, 1'b0, 1'b1);
  endtask

  task automatic test_done_hold();
    bit hold_ok = 1;
    rforce = 1'b0;
    drive_job0("done_hold_job", 5, 30, 1'b0, 1'b0);
    cv0_cnt = 0;
    repeat (10) begin
      b0.inValid = 1'b1; b0.inLast = 1'($urandom);
      b0.inTop = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (b0.inReady !== 1'b0 || b0.outValid !== 1'b1 || b0.checkValid !== 1'b0 ||
          b0.outPermCount !== exp_perm0 || b0.outPairCount !== exp_pair0) hold_ok = 0;
    end
    tests++;
    if (hold_ok !== 1'b1 || cv0_cnt !== 0) begin
      fails++; $display("FAIL done_hold: stable=%b checkValid count=%0d want 1 0", hold_ok, cv0_cnt);
    end
    release0("done_hold");
    drive_job0("after_hold", 4, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random_jobs();
    rforce = 1'b0;
    for (int j = 0; j < 6; j++) drive_job0("random_job", $urandom_range(1, 20), 30, 1'b0, 1'b1);
  endtask

  task automatic run1(input string nm, input int n, input logic [23:0] c);
    longint perm = 0;
    int zero = 0, last_t = 0, waited = 0;
    bit rdy_ok = 1;
    logic [CW1-1:0] ep, eq, ez;
    rforce = 1'b1; rconst = c; cv1_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (b1.inReady !== 1'b1) rdy_ok = 0;
      b1.inValid = 1'b1; b1.inLast = (i == n - 1);
      b1.inTop = {$urandom, $urandom, $urandom, $urandom}; b1.inBot = {$urandom, $urandom, $urandom, $urandom};
      perm += $countones(c);
      if (c == 24'h0) zero++;
      last_t = cyc;
    end
    @(negedge clk);
    b1.inValid = 1'b0;
    while (b1.outValid !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    ep = (perm > 63) ? 6'd63 : CW1'(perm);
    eq = (n > 63) ? 6'd63 : CW1'(n);
    ez = (zero > 63) ? 6'd63 : CW1'(zero);
    tests++;
    if (waited >= 60 || cyc - last_t !== 3 + L1 || rdy_ok !== 1'b1 || cv1_cnt !== n) begin
      fails++; $display("FAIL %s timing: latency=%0d want %0d ready_ok=%b issues=%0d want %0d",
                        nm, cyc - last_t, 3 + L1, rdy_ok, cv1_cnt, n);
    end
    tests++;
    if (b1.outPermCount !== ep || b1.outPairCount !== eq) begin
      fails++; $display("FAIL %s totals: perm=%0d pairs=%0d want %0d %0d", nm, b1.outPermCount, b1.outPairCount, ep, eq);
    end
`ifdef PERMUTE_SCHED_ZERO_COUNT_EN
    tests++;
    if (b1.outZeroCount !== ez) begin
      fails++; $display("FAIL %s zero_count: got %0d want %0d", nm, b1.outZeroCount, ez);
    end
`else
    ez = '0;
`endif
    b1.outReady = 1'b1;
    @(negedge clk);
    b1.outReady = 1'b0;
    tests++;
    if (b1.outValid !== 1'b0 || b1.inReady !== 1'b1 || b1.outPermCount !== '0) begin
      fails++; $display("FAIL %s release: outValid=%b inReady=%b perm=%0d want 0 1 0", nm, b1.outValid, b1.inReady, b1.outPermCount);
    end
  endtask

  task automatic test_saturation();
    run1("sat_perm", 3, 24'hFFFFFF);
    run1("sat_pairs", 70, 24'h0);
  endtask

  task automatic test_reset_midjob();
    rforce = 1'b1; rconst = 24'hFFFFFF;
    @(negedge clk);
    b0.inValid = 1'b1; b0.inLast = 1'b0;
    b0.inTop = {$urandom, $urandom, $urandom, $urandom}; b0.inBot = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    b0.inLast = 1'b1;
    b0.inTop = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    b0.inValid = 1'b0; b0.inLast = 1'b0;
    tests++;
    if (b0.busy !== 1'b1 || b0.checkValid !== 1'b1 || b0.inReady !== 1'b0) begin
      fails++; $display("FAIL rst_mid drain: busy=%b checkValid=%b inReady=%b want 1 1 0", b0.busy, b0.checkValid, b0.inReady);
    end
    rst_n = 1'b0;
    #1;
    cv0_cnt = 0;
    tests++;
    if ({b0.checkValid, b0.inReady, b0.outValid, b0.busy} !== 4'h0 || b0.checkTop !== '0 ||
        b0.checkBot !== '0 || b0.outPermCount !== '0 || b0.outPairCount !== '0) begin
      fails++; $display("FAIL rst_mid outputs: checkValid=%b inReady=%b outValid=%b busy=%b want all 0",
                        b0.checkValid, b0.inReady, b0.outValid, b0.busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (cv0_cnt !== 0) begin
      fails++; $display("FAIL rst_mid strobes: checkValid count=%0d want 0", cv0_cnt);
    end
    rst_n = 1'b1;
    drive_job0("rst_mid_new_job", 1, 0, 1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.inValid = 1'b0; b0.inTop = '0; b0.inBot = '0; b0.inLast = 1'b0; b0.outReady = 1'b0;
    b1.inValid = 1'b0; b1.inTop = '0; b1.inBot = '0; b1.inLast = 1'b0; b1.outReady = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_results();
    test_done_hold();
    test_random_jobs();
    test_saturation();
    test_reset_midjob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
